// File: rtl/br_predictor_pkg.sv
// Branch predictor shared constants, entry/update bundles and helpers.
// Imported by the BTB storage, the interface and the predictor top.
package br_predictor_pkg;

    localparam int PC_SZ       = 32;
    localparam int BTB_IDX_SZ  = 6;
    localparam int BTB_ENTRIES = 1 << BTB_IDX_SZ;
    localparam int BTB_TAG_SZ  = PC_SZ - BTB_IDX_SZ - 1;

    typedef logic [PC_SZ-1:0]      pc_t;
    typedef logic [BTB_IDX_SZ-1:0] btb_idx_t;
    typedef logic [BTB_TAG_SZ-1:0] btb_tag_t;

    typedef struct packed {
        btb_tag_t   tag;
        pc_t        target;
        logic [1:0] ctr;
    } BTB_ENTRY_TYPE;

    typedef struct packed {
        pc_t  pc;
        logic is_jmp;
        logic taken;
        pc_t  target;
    } BTB_UPD_TYPE;

    // Halfword-aligned index so compressed instructions get their own slot.
    function automatic btb_idx_t pc_idx(input pc_t pc);
        return pc[BTB_IDX_SZ:1];
    endfunction

    function automatic btb_tag_t pc_tag(input pc_t pc);
        return pc[PC_SZ-1:BTB_IDX_SZ+1];
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

endpackage

// File: rtl/br_predictor_if.sv
// Fetch lookup / prediction and EXE update bus of the branch predictor.
// master = fetch+exe side (drives lk_*, upd_*); slave = predictor.
interface br_predictor_if
    import br_predictor_pkg::*;
();

    logic lk_valid_in;
    pc_t  lk_pc_in;

    logic pr_valid_out;
    logic pr_hit_out;
    logic pr_taken_out;
    pc_t  pr_target_out;

    logic upd_valid_in;
    pc_t  upd_pc_in;
    logic upd_is_jmp_in;
    logic upd_taken_in;
    pc_t  upd_target_in;

    modport master (
        output lk_valid_in, lk_pc_in,
        output upd_valid_in, upd_pc_in, upd_is_jmp_in,
        output upd_taken_in, upd_target_in,
        input  pr_valid_out, pr_hit_out, pr_taken_out, pr_target_out
    );

    modport slave (
        input  lk_valid_in, lk_pc_in,
        input  upd_valid_in, upd_pc_in, upd_is_jmp_in,
        input  upd_taken_in, upd_target_in,
        output pr_valid_out, pr_hit_out, pr_taken_out, pr_target_out
    );

endinterface

// File: rtl/br_predictor_btb_ram.sv
// BTB storage: flop array of {tag,target,ctr} plus a separate valid vector.
// Ports: two comb read ports (lookup, update), one write port, 1-cycle flush.
module br_predictor_btb_ram
    import br_predictor_pkg::*;
(
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          flush_in,
    input  btb_idx_t      lk_idx_in,
    output logic          lk_valid_out,
    output BTB_ENTRY_TYPE lk_entry_out,
    input  btb_idx_t      ud_idx_in,
    output logic          ud_valid_out,
    output BTB_ENTRY_TYPE ud_entry_out,
    input  logic          wr_en_in,
    input  btb_idx_t      wr_idx_in,
    input  BTB_ENTRY_TYPE wr_entry_in
);

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [BTB_ENTRIES-1:0] valid_d;
    BTB_ENTRY_TYPE          mem_q [BTB_ENTRIES];

    always_comb begin
        valid_d = valid_q;
        if (flush_in) begin
            valid_d = '0;
        end else if (wr_en_in) begin
            valid_d[wr_idx_in] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: it is only ever observed through valid_q.
    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            mem_q[wr_idx_in] <= wr_entry_in;
        end
    end

    assign lk_valid_out = valid_q[lk_idx_in];
    assign lk_entry_out = mem_q[lk_idx_in];
    assign ud_valid_out = valid_q[ud_idx_in];
    assign ud_entry_out = mem_q[ud_idx_in];

endmodule

// File: rtl/br_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB + 2-bit direction counters.
// Ports: clk_in, reset_in (async high), flush_in, bus (lookup/predict/update).
module br_predictor
    import br_predictor_pkg::*;
(
    input  logic           clk_in,
    input  logic           reset_in,
    input  logic           flush_in,
    br_predictor_if.slave  bus
);

    // Lookup side
    logic          lk_vld;
    BTB_ENTRY_TYPE lk_entry;
    logic          lk_hit;

    logic pr_valid_q,  pr_valid_d;
    logic pr_hit_q,    pr_hit_d;
    logic pr_taken_q,  pr_taken_d;
    pc_t  pr_target_q, pr_target_d;

    // Update side
    BTB_UPD_TYPE   pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic          ud_vld;
    BTB_ENTRY_TYPE ud_entry;
    logic          ud_hit;
    logic          wr_en;
    BTB_ENTRY_TYPE wr_entry;

    br_predictor_btb_ram u_ram (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .flush_in     (flush_in),
        .lk_idx_in    (pc_idx(bus.lk_pc_in)),
        .lk_valid_out (lk_vld),
        .lk_entry_out (lk_entry),
        .ud_idx_in    (pc_idx(pend_q.pc)),
        .ud_valid_out (ud_vld),
        .ud_entry_out (ud_entry),
        .wr_en_in     (wr_en),
        .wr_idx_in    (pc_idx(pend_q.pc)),
        .wr_entry_in  (wr_entry)
    );

    // A lookup during flush must already see the cleared table.
    always_comb begin
        lk_hit = bus.lk_valid_in & lk_vld & ~flush_in
               & (lk_entry.tag == pc_tag(bus.lk_pc_in));
        pr_valid_d  = bus.lk_valid_in;
        pr_hit_d    = lk_hit;
        pr_taken_d  = lk_hit & lk_entry.ctr[1];
        pr_target_d = lk_hit ? lk_entry.target : '0;
    end

    always_comb begin
        pend_valid_d  = bus.upd_valid_in & ~flush_in;
        pend_d.pc     = bus.upd_pc_in;
        pend_d.is_jmp = bus.upd_is_jmp_in;
        pend_d.taken  = bus.upd_taken_in;
        pend_d.target = bus.upd_target_in;
    end

    // Writes land in the flop array before the next apply reads it, so a
    // back-to-back update to the same index sees the previous result.
    always_comb begin
        ud_hit   = ud_vld & (ud_entry.tag == pc_tag(pend_q.pc));
        wr_en    = 1'b0;
        wr_entry = ud_entry;
        if (pend_valid_q && !flush_in) begin
            if (ud_hit) begin
                wr_en = 1'b1;
                if (pend_q.is_jmp) begin
                    wr_entry.ctr    = 2'b11;
                    wr_entry.target = pend_q.target;
                end else if (pend_q.taken) begin
                    wr_entry.ctr    = sat_inc(ud_entry.ctr);
                    wr_entry.target = pend_q.target;
                end else begin
                    wr_entry.ctr    = sat_dec(ud_entry.ctr);
                end
            end else if (pend_q.taken) begin
                wr_en           = 1'b1;
                wr_entry.tag    = pc_tag(pend_q.pc);
                wr_entry.target = pend_q.target;
                wr_entry.ctr    = pend_q.is_jmp ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            pr_valid_q   <= 1'b0;
            pr_hit_q     <= 1'b0;
            pr_taken_q   <= 1'b0;
            pr_target_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            pr_valid_q   <= pr_valid_d;
            pr_hit_q     <= pr_hit_d;
            pr_taken_q   <= pr_taken_d;
            pr_target_q  <= pr_target_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
        end
    end

    assign bus.pr_valid_out  = pr_valid_q;
    assign bus.pr_hit_out    = pr_hit_q;
    assign bus.pr_taken_out  = pr_taken_q;
    assign bus.pr_target_out = pr_target_q;

endmodule

// File: tb/tb_br_predictor.sv
// Directed bench for br_predictor: lookup, training, saturation, conflicts,
// same-cycle collisions, flush and mid-operation reset.
module tb_br_predictor;
    import br_predictor_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

    br_predictor_if bus ();

    br_predictor dut (
        .clk_in   (clk),
        .reset_in (rst),
        .flush_in (flush),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic v, input logic h,
                       input logic t, input logic [31:0] tg);
        logic [34:0] obs;
        logic [34:0] exp;
        obs = {bus.pr_valid_out, bus.pr_hit_out, bus.pr_taken_out,
               bus.pr_target_out};
        exp = {v, h, t, tg};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got v/h/t/tgt=%b/%b/%b/%h exp=%b/%b/%b/%h",
                   nm, obs[34], obs[33], obs[32], obs[31:0],
                   v, h, t, tg);
        end
    endtask

    task automatic look(input logic [31:0] pc);
        bus.lk_valid_in = 1'b1;
        bus.lk_pc_in    = pc;
        tick();
        bus.lk_valid_in = 1'b0;
        bus.lk_pc_in    = '0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic j,
                       input logic tk, input logic [31:0] tg);
        bus.upd_valid_in  = 1'b1;
        bus.upd_pc_in     = pc;
        bus.upd_is_jmp_in = j;
        bus.upd_taken_in  = tk;
        bus.upd_target_in = tg;
        tick();
        bus.upd_valid_in  = 1'b0;
    endtask

    initial begin
        bus.lk_valid_in   = 1'b0;
        bus.lk_pc_in      = '0;
        bus.upd_valid_in  = 1'b0;
        bus.upd_pc_in     = '0;
        bus.upd_is_jmp_in = 1'b0;
        bus.upd_taken_in  = 1'b0;
        bus.upd_target_in = '0;

        bus.lk_valid_in = 1'b1;
        bus.lk_pc_in    = 32'h100;
        tick();
        tick();
        chk("reset", 0, 0, 0, 0);
        bus.lk_valid_in = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle", 0, 0, 0, 0);

        // 1: cold lookup misses
        look(32'h100);
        chk("cold", 1, 0, 0, 0);

        // 2: train taken; lookup in apply cycle still sees old data
        upd(32'h100, 0, 1, 32'h80);
        look(32'h100);
        chk("same_cyc", 1, 0, 0, 0);
        look(32'h100);
        chk("train", 1, 1, 1, 32'h80);

        // 3: counter walk 10->01->00->00->01->10->11->11->10->01
        upd(32'h100, 0, 0, 32'hdead0); tick(); look(32'h100);
        chk("nt1", 1, 1, 0, 32'h80);
        upd(32'h100, 0, 0, 32'hdead0); tick(); look(32'h100);
        chk("nt2", 1, 1, 0, 32'h80);
        upd(32'h100, 0, 0, 32'hdead0); tick(); look(32'h100);
        chk("sat0", 1, 1, 0, 32'h80);
        upd(32'h100, 0, 1, 32'h80); tick(); look(32'h100);
        chk("t1", 1, 1, 0, 32'h80);
        upd(32'h100, 0, 1, 32'h88); tick(); look(32'h100);
        chk("t2", 1, 1, 1, 32'h88);
        upd(32'h100, 0, 1, 32'h88); tick(); look(32'h100);
        chk("t3", 1, 1, 1, 32'h88);
        upd(32'h100, 0, 1, 32'h88); tick(); look(32'h100);
        chk("sat3", 1, 1, 1, 32'h88);
        upd(32'h100, 0, 0, 32'hdead0); tick(); look(32'h100);
        chk("dn3", 1, 1, 1, 32'h88);
        upd(32'h100, 0, 0, 32'hdead0); tick(); look(32'h100);
        chk("dn2", 1, 1, 0, 32'h88);

        // 4: conflicting PC at same index replaces; !taken never evicts
        upd(32'h180, 1, 1, 32'h200); tick();
        look(32'h100);
        chk("evict", 1, 0, 0, 0);
        look(32'h180);
        chk("jal", 1, 1, 1, 32'h200);
        upd(32'h100, 0, 0, 32'h44); tick();
        look(32'h180);
        chk("noevict", 1, 1, 1, 32'h200);
        look(32'h100);
        chk("noalloc", 1, 0, 0, 0);

        // 5: back-to-back updates: 11 -> 10 -> 01
        upd(32'h180, 0, 0, 0);
        upd(32'h180, 0, 0, 0);
        tick();
        look(32'h180);
        chk("b2b", 1, 1, 0, 32'h200);
        upd(32'h180, 1, 1, 32'h204); tick();
        upd(32'h180, 0, 0, 0); tick();
        look(32'h180);
        chk("jmp_hit", 1, 1, 1, 32'h204);

        // 6a: flush with concurrent update and lookup
        flush = 1'b1;
        bus.lk_valid_in = 1'b1;
        bus.lk_pc_in    = 32'h180;
        upd(32'h2c0, 0, 1, 32'h300);
        flush = 1'b0;
        bus.lk_valid_in = 1'b0;
        chk("flush_lk", 1, 0, 0, 0);
        tick();
        look(32'h2c0);
        chk("flush_upd", 1, 0, 0, 0);
        look(32'h180);
        chk("flush_old", 1, 0, 0, 0);

        // 6b: flush during apply drops the pending update
        upd(32'h340, 0, 1, 32'h300);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        look(32'h340);
        chk("flush_pend", 1, 0, 0, 0);

        // 6c: reset with lookup and update in flight
        bus.lk_valid_in = 1'b1;
        bus.lk_pc_in    = 32'h100;
        upd(32'h100, 0, 1, 32'h40);
        bus.lk_valid_in = 1'b0;
        chk("pre_rst", 1, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_async", 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        look(32'h100);
        chk("rst_drop", 1, 0, 0, 0);
        upd(32'h100, 0, 1, 32'h44); tick();
        look(32'h100);
        chk("retrain", 1, 1, 1, 32'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
